bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Memory-mapped 32-bit timer/counter peripheral on the SoC system bus; decoded at 0xF1000000 by the top-level bus logic.
- Counts prescaled clock ticks up to a programmable compare value, then wraps to 0 and raises a sticky match flag.
- Supports free-run, periodic and one-shot operation.
- Read data is always presented and registered by the bus mux; writes are qualified by chip select.

Parameters:
- WIDTH, 32, width of data bus, counter and compare registers.
- PRESCALE_BITS, 8, width of the prescaler divisor field.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; clock clk.
- chipSelect  input  1  bus address decodes to this timer; writes are ignored when low.
- write  input  1  write strobe for the data/compare register (bus offset 0x0).
- writeCommand  input  1  write strobe for the command register (bus offset 0x4).
- dataIn  input  WIDTH  bus write data.
- dataOut  output  WIDTH  current counter value, combinational from the counter register.
- match  output  1  sticky match/overflow flag; last positional port, may be left unconnected.

Behaviour:
- Reset (reset==0 at a rising edge): counter=0, compare=0, enable=0, oneshot=0, prescale=0, prescaler count=0, match=0. dataOut therefore reads 0.
- Data write (chipSelect && write): compare <= dataIn. Counter is unchanged.
- Command write (chipSelect && writeCommand), dataIn fields:
  - [0] ENABLE, stored.
  - [1] CLEAR, one-shot action: counter and prescaler count <= 0.
  - [2] ONESHOT, stored.
  - [3] CLRFLAG, one-shot action: match <= 0.
  - [15:8] PRESCALE, stored.
  - All other bits are ignored.
- If write and writeCommand are both high in the same cycle, both writes take effect.
- Prescaler:
  - While enabled, the prescaler count increments each clock.
  - A tick occurs when count == PRESCALE; the count then returns to 0.
  - While disabled, the prescaler count is held at 0.
  - Tick period is PRESCALE+1 clocks.
- On a tick:
  - compare != 0 and counter == compare: counter <= 0, match <= 1; if ONESHOT, ENABLE <= 0.
  - compare == 0: free-run. Counter increments and wraps 0xFFFFFFFF -> 0, setting match on the wrap.
  - Otherwise: counter <= counter+1.
  - Periodic period is (compare+1)*(PRESCALE+1) clocks.
- Latency:
  - A command write at edge N takes effect at edge N. With PRESCALE=0, the first increment is at edge N+1, so counter=1 after edge N+1.
- Priorities:
  - CLEAR overrides a tick in the same cycle.
  - A match event overrides CLRFLAG in the same cycle (flag stays set).
  - A command write with ENABLE=1 and CLEAR=1 starts counting from 0.
- Mid-operation changes:
  - Changing compare below the current counter value: counter runs to the wrap (or to 0xFFFFFFFF) before matching.
  - Reset mid-count returns all state to reset values immediately at that edge.
- dataOut has no read-strobe side effects. Reading never clears match.

Test Plan:
- Reset: hold reset=0 for 2 clocks with random strobes -> dataOut=0, match=0; writes during reset are ignored.
- Periodic: write compare=4, command=0x1 -> counter sequence 1,2,3,4,0; match=1 at the wrap, 5 clocks after enable; counting continues.
- Prescale: compare=2, command=0x0301 (PRESCALE=3, enable) -> counter increments every 4 clocks; match set after 12 clocks.
- One-shot: compare=3, command=0x5 -> after the match the counter holds 0 and ENABLE=0; match=1. Command 0x8 -> match=0.
- Clear/priority: counting with compare=0; command=0x3 -> counter=0 that edge, then 1. CLRFLAG in the same cycle as a match -> match remains 1.
- Chip select: write/writeCommand pulsed with chipSelect=0 -> no register change; free-run from 0xFFFFFFFE wraps to 0 and sets match.

Source files
------------

// File: rtl/bus_timer.sv
// Memory-mapped timer/counter: prescaled tick counter with compare/wrap,
// sticky match flag, and free-run / periodic / one-shot operation.
module bus_timer #(
    parameter int WIDTH         = 32,
    parameter int PRESCALE_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipSelect,
    input  logic             write,
    input  logic             writeCommand,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             match
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]         counter_q, counter_d;
    logic [WIDTH-1:0]         compare_q, compare_d;
    logic                     enable_q, enable_d;
    logic                     oneshot_q, oneshot_d;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [PRESCALE_BITS-1:0] pcount_q, pcount_d;
    logic                     match_q, match_d;

    logic wr_data;
    logic wr_cmd;
    logic tick;
    logic hit;
    logic match_evt;

    assign wr_data = chipSelect && write;
    assign wr_cmd  = chipSelect && writeCommand;
    assign tick    = enable_q && (pcount_q == prescale_q);
    assign hit     = (compare_q != '0) && (counter_q == compare_q);

    always_comb begin
        counter_d  = counter_q;
        compare_d  = compare_q;
        enable_d   = enable_q;
        oneshot_d  = oneshot_q;
        prescale_d = prescale_q;
        pcount_d   = '0;
        match_d    = match_q;
        match_evt  = 1'b0;

        if (enable_q) begin
            pcount_d = tick ? '0 : pcount_q + 1'b1;
        end

        if (tick) begin
            if (hit) begin
                counter_d = '0;
                match_evt = 1'b1;
                if (oneshot_q) begin
                    enable_d = 1'b0;
                end
            end else begin
                counter_d = counter_q + 1'b1;
                // Only free-run mode reports the natural wrap as a match.
                match_evt = (compare_q == '0) && (counter_q == CNT_MAX);
            end
        end

        if (wr_data) begin
            compare_d = dataIn;
        end

        if (wr_cmd) begin
            enable_d   = dataIn[0];
            oneshot_d  = dataIn[2];
            prescale_d = dataIn[8 +: PRESCALE_BITS];
            // CLEAR discards the whole tick of this cycle, including its match.
            if (dataIn[1]) begin
                counter_d = '0;
                pcount_d  = '0;
                match_evt = 1'b0;
            end
            if (dataIn[3]) begin
                match_d = 1'b0;
            end
        end

        if (match_evt) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_q  <= '0;
            compare_q  <= '0;
            enable_q   <= 1'b0;
            oneshot_q  <= 1'b0;
            prescale_q <= '0;
            pcount_q   <= '0;
            match_q    <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            compare_q  <= compare_d;
            enable_q   <= enable_d;
            oneshot_q  <= oneshot_d;
            prescale_q <= prescale_d;
            pcount_q   <= pcount_d;
            match_q    <= match_d;
        end
    end

    assign dataOut = counter_q;
    assign match   = match_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios, then random bus
// traffic against a behavioural model, then a narrow instance for the wrap.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, wr, wc;
    logic [31:0] din;
    logic [31:0] dout;
    logic        mtch;

    logic        s_cs, s_wr, s_wc;
    logic [11:0] s_din;
    logic [11:0] s_dout;
    logic        s_mtch;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [31:0] m_cnt, m_cmp;
    logic        m_en, m_os, m_match;
    int          m_ps, m_phase;

    always #5 clk = ~clk;

    bus_timer dut (
        .clk(clk), .reset(reset), .chipSelect(cs), .write(wr),
        .writeCommand(wc), .dataIn(din), .dataOut(dout), .match(mtch)
    );

    bus_timer #(.WIDTH(12), .PRESCALE_BITS(4)) dut_s (
        .clk(clk), .reset(reset), .chipSelect(s_cs), .write(s_wr),
        .writeCommand(s_wc), .dataIn(s_din), .dataOut(s_dout), .match(s_mtch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock of the model: ticks every (PRESCALE+1) enabled clocks.
    task automatic model_step(input logic r, input logic c, input logic w,
                              input logic k, input logic [31:0] d);
        logic        ticked, evt;
        logic [31:0] n_cnt;
        logic        n_en;
        int          n_phase;
        if (!r) begin
            m_cnt = 0; m_cmp = 0; m_en = 0; m_os = 0;
            m_ps = 0; m_phase = 0; m_match = 0;
            return;
        end
        ticked  = m_en && (m_phase == m_ps);
        n_phase = !m_en ? 0 : (ticked ? 0 : m_phase + 1);
        n_cnt   = m_cnt;
        n_en    = m_en;
        evt     = 0;
        if (ticked) begin
            if (m_cmp != 0 && m_cnt == m_cmp) begin
                n_cnt = 0; evt = 1;
                if (m_os) n_en = 0;
            end else begin
                n_cnt = m_cnt + 32'd1;
                evt   = (m_cmp == 0) && (m_cnt == 32'hFFFF_FFFF);
            end
        end
        if (c && w) m_cmp = d;
        if (c && k) begin
            n_en = d[0];
            m_os = d[2];
            m_ps = int'(d[15:8]);
            if (d[1]) begin n_cnt = 0; n_phase = 0; evt = 0; end
            if (d[3]) m_match = 0;
        end
        if (evt) m_match = 1;
        m_cnt = n_cnt; m_en = n_en; m_phase = n_phase;
    endtask

    task automatic cyc(input logic r, input logic c, input logic w,
                       input logic k, input logic [31:0] d);
        reset = r; cs = c; wr = w; wc = k; din = d;
        @(posedge clk);
        model_step(r, c, w, k, d);
        #1;
        check("model_cnt", dout, m_cnt);
        check("model_match", {31'd0, mtch}, {31'd0, m_match});
        reset = 1'b1; cs = 0; wr = 0; wc = 0; din = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, $urandom);
    endtask

    task automatic do_reset();
        cyc(0, $urandom, $urandom, $urandom, $urandom);
        cyc(0, $urandom, $urandom, $urandom, $urandom);
    endtask

    initial begin
        reset = 0; cs = 0; wr = 0; wc = 0; din = 0;
        s_cs = 0; s_wr = 0; s_wc = 0; s_din = 0;
        model_step(0, 0, 0, 0, 0);

        // reset with random strobes
        do_reset();
        check("rst_dout", dout, 0);
        check("rst_match", {31'd0, mtch}, 0);

        // periodic, compare=4
        cyc(1, 1, 1, 0, 32'd4);
        cyc(1, 1, 0, 1, 32'h1);
        check("per_start", dout, 0);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            check("per_seq", dout, i);
            check("per_nomatch", {31'd0, mtch}, 0);
        end
        idle(1);
        check("per_wrap", dout, 0);
        check("per_match", {31'd0, mtch}, 1);
        idle(1);
        check("per_cont", dout, 1);

        // prescale=3, compare=2
        do_reset();
        cyc(1, 1, 1, 0, 32'd2);
        cyc(1, 1, 0, 1, 32'h0301);
        idle(3);
        check("ps_hold", dout, 0);
        idle(1);
        check("ps_first", dout, 1);
        idle(7);
        check("ps_nomatch", {31'd0, mtch}, 0);
        idle(1);
        check("ps_match", {31'd0, mtch}, 1);
        check("ps_wrap", dout, 0);

        // one-shot, compare=3
        do_reset();
        cyc(1, 1, 1, 0, 32'd3);
        cyc(1, 1, 0, 1, 32'h5);
        idle(3);
        check("os_cnt3", dout, 3);
        idle(1);
        check("os_match", {31'd0, mtch}, 1);
        idle(6);
        check("os_held", dout, 0);
        check("os_sticky", {31'd0, mtch}, 1);
        cyc(1, 1, 0, 1, 32'h8);
        check("os_clrflag", {31'd0, mtch}, 0);

        // clear while free-running
        do_reset();
        cyc(1, 1, 0, 1, 32'h1);
        idle(5);
        check("clr_pre", dout, 5);
        cyc(1, 1, 0, 1, 32'h3);
        check("clr_zero", dout, 0);
        idle(1);
        check("clr_restart", dout, 1);

        // match beats CLRFLAG in the same cycle
        do_reset();
        cyc(1, 1, 1, 0, 32'd2);
        cyc(1, 1, 0, 1, 32'h1);
        idle(2);
        cyc(1, 1, 0, 1, 32'h9);
        check("prio_match", {31'd0, mtch}, 1);
        check("prio_wrap", dout, 0);
        cyc(1, 1, 0, 1, 32'h9);
        check("prio_clr", {31'd0, mtch}, 0);

        // strobes without chip select are ignored
        cyc(1, 0, 1, 1, 32'h0000_0002);
        check("cs_noclear", dout, 2);
        idle(1);
        check("cs_nocmp", dout, 0);
        check("cs_match", {31'd0, mtch}, 1);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] d;
            int          sel;
            sel = $urandom_range(0, 99);
            d   = {16'd0, 6'd0, 2'($urandom_range(0, 3)), 4'd0, 4'($urandom)};
            if (sel < 2)       cyc(0, $urandom, $urandom, $urandom, $urandom);
            else if (sel < 8)  cyc(1, $urandom, 1, $urandom, 32'($urandom_range(0, 9)));
            else if (sel < 14) cyc(1, $urandom_range(0, 3) != 0, $urandom, 1, d);
            else               idle(1);
        end

        // narrow instance: free-run wrap from the top value
        do_reset();
        s_cs = 1; s_wc = 1; s_din = 12'h001;
        @(posedge clk); #1;
        s_cs = 0; s_wc = 0; s_din = 0;
        begin
            int n = 0;
            while (s_dout != 12'hFFE && n < 5000) begin
                @(posedge clk); #1; n++;
            end
            check("wrap_reach", {20'd0, s_dout}, 32'hFFE);
        end
        check("wrap_pre_match", {31'd0, s_mtch}, 0);
        @(posedge clk); #1;
        check("wrap_top", {20'd0, s_dout}, 32'hFFF);
        @(posedge clk); #1;
        check("wrap_zero", {20'd0, s_dout}, 0);
        check("wrap_match", {31'd0, s_mtch}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
